// File: rtl/uart_rx_core.sv
// 8-N-1 UART receive engine: synchronises the line, majority-votes each bit at mid-bit,
// checks the stop bit and holds each byte behind a valid/ack handshake.
module uart_rx_core #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       rx_sample_tick,
  input  logic       rx_serial_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] SampLo   = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] SampMid  = CntW'(OVERSAMPLE / 2);
  localparam logic [CntW-1:0] SampHi   = CntW'(OVERSAMPLE / 2 + 1);
  localparam logic [CntW-1:0] SampLast = CntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_bit_idx;
  logic            r_s7;
  logic            r_s8;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun_err;

  logic            w_rx_s;
  logic            w_vote;
  logic [CntW-1:0] w_cnt_inc;

  assign w_rx_s    = r_sync2;
  assign w_vote    = (r_s7 & r_s8) | (r_s7 & w_rx_s) | (r_s8 & w_rx_s);
  assign w_cnt_inc = (r_cnt == SampLast) ? '0 : r_cnt + CntOne;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_s7          <= 1'b1;
      r_s8          <= 1'b1;
      r_shift       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_sync1       <= rx_serial_in;
      r_sync2       <= r_sync1;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
      if (rx_ack && r_valid) r_valid <= 1'b0;

      if (rx_sample_tick) begin
        if (r_cnt == SampLo)  r_s7 <= w_rx_s;
        if (r_cnt == SampMid) r_s8 <= w_rx_s;
        case (r_state)
          StIdle: begin
            if (!w_rx_s) begin
              r_state <= StStart;
              r_cnt   <= CntOne;
            end
          end
          StStart: begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == SampHi && w_vote) begin
              r_state <= StIdle;
              r_cnt   <= '0;
            end else if (r_cnt == SampLast) begin
              r_state   <= StData;
              r_bit_idx <= '0;
            end
          end
          StData: begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == SampHi) r_shift <= {w_vote, r_shift[7:1]};
            if (r_cnt == SampLast) begin
              if (r_bit_idx == 3'd7) r_state <= StStop;
              else                   r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
          StStop: begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == SampHi) begin
              r_cnt <= '0;
              if (w_vote) begin
                r_state <= StIdle;
                // An ack in the same cycle frees the holding register for the new byte.
                if (!r_valid || rx_ack) begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
                end else begin
                  r_overrun_err <= 1'b1;
                end
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= StBreak;
              end
            end
          end
          StBreak: begin
            if (w_rx_s) r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign rx_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are driven one sample tick at a time and
// expected bytes are queued, then checked as the receiver delivers them.
module tb_uart_rx_core;

  logic       clk_50mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_sample_tick = 1'b0;
  logic       rx_serial_in = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  int         n_checks = 0;
  int         n_pass = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  logic [7:0] exp_q[$];
  logic       p_valid = 1'b0;
  logic [7:0] p_data = 8'h00;

  uart_rx_core #(.OVERSAMPLE(16)) dut (
    .clk_50mhz     (clk_50mhz),
    .rst_n         (rst_n),
    .rx_sample_tick(rx_sample_tick),
    .rx_serial_in  (rx_serial_in),
    .rx_ack        (rx_ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err),
    .rx_busy       (rx_busy)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // One tick every 4 clocks, changed 2 ns after the edge so it is stable for the next edge.
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk_50mhz);
      #2;
      tc = (tc == 3) ? 0 : tc + 1;
      rx_sample_tick = (tc == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // Delivery monitor: a new byte shows up as rx_valid rising or rx_data changing while valid.
  initial begin
    forever begin
      @(negedge clk_50mhz);
      if (frame_err) n_ferr++;
      if (overrun_err) n_ovr++;
      if (rx_valid && (!p_valid || rx_data != p_data)) begin
        if (exp_q.size() == 0) check_eq("sb_spurious_byte", 32'(exp_q.size()), 32'd1);
        else check_eq("sb_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      p_valid = rx_valid;
      p_data  = rx_data;
    end
  end

  // Present one line value for exactly one sample tick; returns 3 ns after that tick's edge.
  task automatic drive_slot(input logic v, input logic ack);
    rx_serial_in = v;
    wait (rx_sample_tick === 1'b1);
    rx_ack = ack;
    @(posedge clk_50mhz);
    #3;
    rx_ack = 1'b0;
  endtask

  task automatic idle_slots(input int n);
    for (int i = 0; i < n; i++) drive_slot(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic glitch,
                            input logic ack_stop, input int stop_len);
    logic v;
    for (int i = 0; i < 144 + stop_len; i++) begin
      int j;
      j = i / 16;
      if (j == 0)      v = 1'b0;
      else if (j <= 8) v = d[j-1];
      else             v = stop_bit;
      if (glitch && (i % 16) == 8) v = ~v;
      drive_slot(v, ack_stop && i == 153);
      if (i == 152) check_eq("busy_before_stop_vote", 32'(rx_busy), 32'd1);
      if (i == 153) begin
        check_eq("busy_after_stop_vote", 32'(rx_busy), 32'(!stop_bit));
        check_eq("frame_err_at_stop", 32'(frame_err), 32'(!stop_bit));
      end
    end
  endtask

  task automatic do_ack();
    check_eq("valid_before_ack", 32'(rx_valid), 32'd1);
    rx_ack = 1'b1;
    @(posedge clk_50mhz);
    #3;
    rx_ack = 1'b0;
    check_eq("valid_after_ack", 32'(rx_valid), 32'd0);
  endtask

  initial begin
    #35;
    rst_n = 1'b1;
    @(posedge clk_50mhz);
    #3;
    check_eq("rst_data", 32'(rx_data), 32'h00);
    check_eq("rst_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_busy", 32'(rx_busy), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_overrun", 32'(overrun_err), 32'd0);
    idle_slots(4);

    // Basic frame and ack.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 16);
    check_eq("a5_data", 32'(rx_data), 32'hA5);
    check_eq("a5_no_ferr", 32'(n_ferr), 32'd0);
    do_ack();

    // False start: low for 3 ticks only.
    for (int i = 0; i < 16; i++) begin
      drive_slot((i < 3) ? 1'b0 : 1'b1, 1'b0);
      if (i == 8) check_eq("false_start_busy_t8", 32'(rx_busy), 32'd1);
      if (i == 9) check_eq("false_start_busy_t9", 32'(rx_busy), 32'd0);
    end
    check_eq("false_start_valid", 32'(rx_valid), 32'd0);
    check_eq("false_start_ferr", 32'(n_ferr), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 16);
    do_ack();

    // Framing error, line held low into break, then recovery.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 40);
    check_eq("break_busy", 32'(rx_busy), 32'd1);
    drive_slot(1'b1, 1'b0);
    check_eq("break_exit_busy", 32'(rx_busy), 32'd0);
    check_eq("ferr_count", 32'(n_ferr), 32'd1);
    check_eq("ferr_valid", 32'(rx_valid), 32'd0);
    idle_slots(4);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 16);
    do_ack();

    // Overrun: second byte lost without an ack.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 16);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 16);
    check_eq("ovr_data_kept", 32'(rx_data), 32'h11);
    check_eq("ovr_valid", 32'(rx_valid), 32'd1);
    check_eq("ovr_count", 32'(n_ovr), 32'd1);
    do_ack();

    // Ack coincident with delivery: new byte replaces old, no overrun.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 16);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, 16);
    check_eq("ack_deliv_data", 32'(rx_data), 32'h22);
    check_eq("ack_deliv_valid", 32'(rx_valid), 32'd1);
    check_eq("ack_deliv_no_ovr", 32'(n_ovr), 32'd1);
    do_ack();

    // Single-sample glitch at sample 8 of every bit is outvoted.
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 16);
    check_eq("glitch_data", 32'(rx_data), 32'h00);
    check_eq("glitch_valid", 32'(rx_valid), 32'd1);
    check_eq("glitch_no_ferr", 32'(n_ferr), 32'd1);

    // Asynchronous reset in the middle of data bit 4, with an unread byte pending.
    for (int i = 0; i < 85; i++) drive_slot(1'b0, 1'b0);
    check_eq("pre_rst_busy", 32'(rx_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_data", 32'(rx_data), 32'h00);
    check_eq("mid_rst_valid", 32'(rx_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(rx_busy), 32'd0);
    check_eq("mid_rst_ferr", 32'(frame_err), 32'd0);
    check_eq("mid_rst_ovr", 32'(overrun_err), 32'd0);
    rx_serial_in = 1'b1;
    repeat (3) @(posedge clk_50mhz);
    #4;
    rst_n = 1'b1;
    idle_slots(4);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 16);
    check_eq("c3_data", 32'(rx_data), 32'hC3);
    idle_slots(2);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    check_eq("final_ferr_count", 32'(n_ferr), 32'd1);
    check_eq("final_ovr_count", 32'(n_ovr), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
